// File: rtl/rotl_pipe.sv
// Pipelined rotate-left unit: one register stage per amount bit, valid/ready with bubble collapse.
// Define ROTL_PIPE_LOGICAL_EN to add in_logical, selecting a zero-fill shift-left instead of a rotate.
module rotl_pipe #(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
`ifdef ROTL_PIPE_LOGICAL_EN
  input  logic             in_logical,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int LAST = AMT_W - 1;

  logic [AMT_W-1:0] valid_q, valid_d, load;
  logic [WIDTH-1:0] data_q    [AMT_W];
  logic [WIDTH-1:0] data_d    [AMT_W];
  logic [AMT_W-1:0] amt_q     [AMT_W];
  logic [AMT_W-1:0] amt_d     [AMT_W];
  logic             logical_q [AMT_W];
  logic             logical_d [AMT_W];
  logic             first_logical;

`ifdef ROTL_PIPE_LOGICAL_EN
  assign first_logical = in_logical;
`else
  assign first_logical = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] stage_op(input logic [WIDTH-1:0] d,
                                                input int unsigned      sh,
                                                input logic             zero_fill);
    logic [WIDTH-1:0] shl, wrap;
    shl  = d << sh;
    wrap = d >> (WIDTH - sh);
    return zero_fill ? shl : (shl | wrap);
  endfunction

  // A stage may load when empty or when its item leaves; walk from the output back to the input.
  always_comb begin
    logic downstream_load;
    // NOTE: every combinational output gets a default before any conditional logic, so no latch is inferred.
    load            = '0;
    downstream_load = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      load[k]         = !valid_q[k] || downstream_load;
      downstream_load = load[k];
    end
  end

  // Stage k rotates by 2^k when the low bit of its remaining amount is set, then drops that bit.
  always_comb begin
    valid_d[0]   = in_valid;
    data_d[0]    = in_amt[0] ? stage_op(in_data, 1, first_logical) : in_data;
    amt_d[0]     = in_amt >> 1;
    logical_d[0] = first_logical;
    for (int k = 1; k < AMT_W; k++) begin
      valid_d[k]   = valid_q[k-1];
      data_d[k]    = amt_q[k-1][0] ? stage_op(data_q[k-1], 1 << k, logical_q[k-1]) : data_q[k-1];
      amt_d[k]     = amt_q[k-1] >> 1;
      logical_d[k] = logical_q[k-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so each stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      // NOTE: payload registers are cleared too, so out_data reads 0 after reset instead of stale data.
      for (int k = 0; k < AMT_W; k++) begin
        data_q[k]    <= '0;
        amt_q[k]     <= '0;
        logical_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < AMT_W; k++) begin
        if (load[k]) begin
          valid_q[k]   <= valid_d[k];
          data_q[k]    <= data_d[k];
          amt_q[k]     <= amt_d[k];
          logical_q[k] <= logical_d[k];
        end
      end
    end
  end

  // Handshakes are masked during reset so nothing transfers in the cycle being discarded.
  assign in_ready  = load[0] && !rst;
  assign out_valid = valid_q[LAST] && !rst;
  assign out_data  = data_q[LAST];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_rotl_pipe.sv
// Self-checking bench for rotl_pipe: directed scenarios plus randomized traffic against a queue model.
module tb_rotl_pipe;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       in_logical;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  rotl_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
`ifdef ROTL_PIPE_LOGICAL_EN
    .in_logical(in_logical),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: rotate-left (or zero-fill shift-left) of an 8-bit value, in plain integer arithmetic.
  function automatic logic [7:0] model(input logic [7:0] d, input int a, input logic lg);
    int v;
    int shl;
    v   = int'(d);
    shl = (v << a) & 255;
    if (lg) return 8'(shl);
    return 8'(shl | (v >> (8 - a)));
  endfunction

  // Scoreboard: push expected results on input transfers, compare on output transfers.
  logic [7:0] exp_q[$];
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      check("busy_vs_model", busy, exp_q.size() != 0);
      if (hold_v) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", out_data, hold_d);
      end
      if (out_valid) begin
        check("out_pending", exp_q.size() != 0, 1);
        if (out_ready && exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      if (in_valid && in_ready) exp_q.push_back(model(in_data, int'(in_amt), in_logical));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // Present one item from posedge+1 and return at posedge+1 after its transfer edge.
  task automatic send(input logic [7:0] d, input int a, input logic lg);
    int n;
    n          = 0;
    in_valid   = 1'b1;
    in_data    = d;
    in_amt     = 3'(a);
    in_logical = lg;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("send_accepted", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [7:0] got_d [8];
  int got_n, got_first, got_last;

  task automatic collect(input int n);
    got_n = 0; got_first = -1; got_last = -1;
    for (int i = 0; i < 8; i++) got_d[i] = 8'h00;
    for (int c = 0; c < 20 && got_n < n; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got_d[got_n] = out_data;
        got_n++;
        if (got_first < 0) got_first = c;
        got_last = c;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check(name, busy, 0);
    @(posedge clk); #1;
  endtask

  logic [7:0] bp_d [5] = '{8'h11, 8'h22, 8'hC3, 8'h44, 8'h9E};
  int lat, acc, outs, first, last, seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_amt = 3'd0;
    in_logical = 1'b0; out_ready = 1'b1;

    // Reset state and first cycle after reset.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_out_data", out_data, 8'h00);
    check("post_rst_busy", busy, 0);
    @(posedge clk); #1;

    // Single op: latency and busy fall.
    send(8'hB4, 3, 1'b0);
    lat = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (out_valid && lat < 0) begin
        lat = c;
        check("single_data", out_data, 8'hA5);
        check("single_busy", busy, 1);
      end
      if (lat >= 0 && c == lat + 1) check("single_busy_fall", busy, 0);
    end
    check("single_latency", lat, 3);
    @(posedge clk); #1;

    // Wrap and identity, back-to-back.
    send(8'h81, 1, 1'b0);
    send(8'h01, 7, 1'b0);
    send(8'h5A, 0, 1'b0);
    collect(3);
    check("wrap_count", got_n, 3);
    check("wrap_81_1", got_d[0], 8'h03);
    check("wrap_01_7", got_d[1], 8'h80);
    check("ident_5A_0", got_d[2], 8'h5A);
    check("wrap_one_per_cycle", got_last - got_first, 2);
    wait_idle("wrap_idle");

    // Backpressure: only three fit, then drain with simultaneous in/out transfers.
    out_ready = 1'b0; acc = 0;
    in_valid = 1'b1; in_data = bp_d[0]; in_amt = 3'(1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
      if (acc < 5) begin in_data = bp_d[acc]; in_amt = 3'(acc + 1); end
      else in_valid = 1'b0;
    end
    check("bp_accepts", acc, 3);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1; outs = 0; first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) check("simul_in_out", {in_ready, out_valid}, 2'b11);
      if (in_valid && in_ready) acc++;
      if (out_valid) begin
        outs++;
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clk); #1;
      if (acc < 5) begin in_data = bp_d[acc]; in_amt = 3'(acc + 1); end
      else in_valid = 1'b0;
    end
    check("bp_all_accepted", acc, 5);
    check("bp_drained", outs, 5);
    check("bp_one_per_cycle", last - first, 4);
    wait_idle("bp_idle");

    // Bubble collapse: one item stalled in the last stage, two more still fit.
    out_ready = 1'b0;
    send(8'h3C, 2, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    acc = 0; in_valid = 1'b1; in_data = 8'hE7; in_amt = 3'd5;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
      in_data = 8'(in_data + 8'h13);
    end
    in_valid = 1'b0;
    check("bubble_accepts", acc, 2);
    out_ready = 1'b1;
    wait_idle("bubble_idle");

    // Reset mid-stream discards everything in flight.
    send(8'hF0, 4, 1'b0);
    send(8'h0F, 6, 1'b0);
    send(8'hAA, 1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_mid_no_stale", seen, 0);
    @(posedge clk); #1;

`ifdef ROTL_PIPE_LOGICAL_EN
    send(8'hB4, 3, 1'b1);
    send(8'hB4, 3, 1'b0);
    collect(2);
    check("logical_count", got_n, 2);
    check("logical_shift", got_d[0], 8'hA0);
    check("logical_rotate", got_d[1], 8'hA5);
    wait_idle("logical_idle");
`endif

    // Randomized traffic with random consumer stalls.
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      in_amt   = 3'($urandom_range(0, 7));
`ifdef ROTL_PIPE_LOGICAL_EN
      in_logical = 1'($urandom);
`else
      in_logical = 1'b0;
`endif
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle("random_idle");
    @(negedge clk);
    check("random_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
